cdb_broadcaster: RTL and testbench

- Producer end of the common data bus (CDB): collects completed results from the functional units and broadcasts them to reservation stations and the register status table.
- Holds one small FIFO per FU and arbitrates up to CDB_LANES results per cycle onto the CDB lanes, using round-robin priority.
- Backpressures FUs through per-FU ready; honours a consumer-side cdb_ready.

---
 rtl/cdb_broadcaster.sv | 199 +++++++++++++++++++
 tb/tb_cdb_broadcaster.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-FU result FIFOs feeding a round-robin arbitrated common data bus.
// Optional statistics counters are compiled in when CDB_BROADCASTER_STATS_EN is defined.

// Generic show-ahead FIFO with full/empty flags.
// Latency: a pushed entry is visible at the head from the next cycle.
// Backpressure: push is dropped while full, even in a cycle that also pops.
module cdb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             empty,
    output logic             full
);
    localparam int PW = (DEPTH <= 1) ? 1 : $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_dat = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop_ok)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end
endmodule

// Collects FU results and broadcasts up to CDB_LANES per cycle, round-robin from rr_ptr.
// Latency: one cycle through the FIFO; push at edge N appears on the CDB from edge N+1.
// Backpressure: fu_ready drops when an FU FIFO is full; lanes hold while cdb_ready is low.
module cdb_broadcaster #(
    parameter int FU_NUM                 = 4,
    parameter int CDB_LANES              = 2,
    parameter int FIFO_DEPTH             = 2,
    parameter int PHYSICAL_REG_NUM_WIDTH = 6,
    parameter int REG_VAL_WIDTH          = 32,
    parameter int FU_IDX_WIDTH           = (FU_NUM <= 1) ? 1 : $clog2(FU_NUM)
) (
    input  logic                                            clk,
    input  logic                                            reset,
    input  logic [FU_NUM-1:0]                               fu_valid,
    output logic [FU_NUM-1:0]                               fu_ready,
    input  logic [FU_NUM-1:0][PHYSICAL_REG_NUM_WIDTH-1:0]   fu_dst_reg_addr,
    input  logic [FU_NUM-1:0][REG_VAL_WIDTH-1:0]            fu_result_val,
    input  logic                                            cdb_ready,
    output logic [CDB_LANES-1:0]                            cdb_valid,
    output logic [CDB_LANES-1:0][PHYSICAL_REG_NUM_WIDTH-1:0] cdb_register_addr,
    output logic [CDB_LANES-1:0][REG_VAL_WIDTH-1:0]         cdb_register_val,
    output logic [CDB_LANES-1:0][FU_IDX_WIDTH-1:0]          cdb_fu_idx
`ifdef CDB_BROADCASTER_STATS_EN
    ,
    output logic [31:0]                                     stat_broadcast_cnt,
    output logic [31:0]                                     stat_fu_stall_cnt
`endif
);
    typedef struct packed {
        logic [PHYSICAL_REG_NUM_WIDTH-1:0] addr;
        logic [REG_VAL_WIDTH-1:0]          val;
    } result_t;

    result_t                 push_dat [FU_NUM];
    result_t                 head_dat [FU_NUM];
    logic [FU_NUM-1:0]       fifo_empty;
    logic [FU_NUM-1:0]       fifo_full;
    logic [FU_NUM-1:0]       pop;
    logic [FU_NUM-1:0]       gnt_vec;
    logic [CDB_LANES-1:0]    lane_gnt;
    logic [FU_IDX_WIDTH-1:0] lane_sel [CDB_LANES];
    logic [FU_IDX_WIDTH-1:0] rr_ptr;
    logic [FU_IDX_WIDTH-1:0] rr_next;
    logic [FU_IDX_WIDTH-1:0] cand;
    logic                    found;
    logic                    load_en;

    for (genvar j = 0; j < FU_NUM; j++) begin : g_fifo
        assign push_dat[j] = '{addr: fu_dst_reg_addr[j], val: fu_result_val[j]};

        cdb_fifo #(
            .WIDTH ($bits(result_t)),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk      (clk),
            .rst_n    (reset),
            .push     (fu_valid[j]),
            .push_dat (push_dat[j]),
            .pop      (pop[j]),
            .head_dat (head_dat[j]),
            .empty    (fifo_empty[j]),
            .full     (fifo_full[j])
        );
    end

    // Readiness comes from the pre-pop count: a full FIFO refuses even while it drains.
    assign fu_ready = ~fifo_full;
    assign load_en  = !(|cdb_valid) || cdb_ready;
    assign pop      = load_en ? gnt_vec : '0;

    // Lane k takes the k-th non-empty FIFO in scan order starting at rr_ptr.
    always_comb begin
        lane_gnt = '0;
        gnt_vec  = '0;
        rr_next  = rr_ptr;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < CDB_LANES; k++)
            lane_sel[k] = '0;
        for (int k = 0; k < CDB_LANES; k++) begin
            found = 1'b0;
            for (int i = 0; i < FU_NUM; i++) begin
                cand = FU_IDX_WIDTH'((int'(rr_ptr) + i) % FU_NUM);
                if (!found && !fifo_empty[cand] && !gnt_vec[cand]) begin
                    found         = 1'b1;
                    lane_gnt[k]   = 1'b1;
                    lane_sel[k]   = cand;
                    gnt_vec[cand] = 1'b1;
                    rr_next       = FU_IDX_WIDTH'((int'(cand) + 1) % FU_NUM);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr            <= '0;
            cdb_valid         <= '0;
            cdb_register_addr <= '0;
            cdb_register_val  <= '0;
            cdb_fu_idx        <= '0;
        end else if (load_en) begin
            rr_ptr    <= rr_next;
            cdb_valid <= lane_gnt;
            for (int k = 0; k < CDB_LANES; k++) begin
                if (lane_gnt[k]) begin
                    cdb_register_addr[k] <= head_dat[lane_sel[k]].addr;
                    cdb_register_val[k]  <= head_dat[lane_sel[k]].val;
                    cdb_fu_idx[k]        <= lane_sel[k];
                end else begin
                    cdb_register_addr[k] <= '0;
                    cdb_register_val[k]  <= '0;
                    cdb_fu_idx[k]        <= '0;
                end
            end
        end
    end

`ifdef CDB_BROADCASTER_STATS_EN
    logic [32:0] bc_sum;
    logic        any_stall;

    assign bc_sum    = {1'b0, stat_broadcast_cnt} + 33'($countones(lane_gnt));
    assign any_stall = |(fu_valid & ~fu_ready);

    // Both counters saturate instead of wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_broadcast_cnt <= '0;
            stat_fu_stall_cnt  <= '0;
        end else begin
            if (load_en)
                stat_broadcast_cnt <= bc_sum[32] ? 32'hFFFF_FFFF : bc_sum[31:0];
            if (any_stall && (stat_fu_stall_cnt != 32'hFFFF_FFFF))
                stat_fu_stall_cnt <= stat_fu_stall_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster with a queue-based reference model checked every cycle.
module tb_cdb_broadcaster;
    localparam int FU_NUM = 4;
    localparam int LANES  = 2;
    localparam int DEPTH  = 2;
    localparam int AW     = 6;
    localparam int VW     = 32;
    localparam int IW     = 2;
    localparam int LW     = AW + VW + IW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                         reset;
    logic [FU_NUM-1:0]            fu_valid;
    logic [FU_NUM-1:0]            fu_ready;
    logic [FU_NUM-1:0][AW-1:0]    fu_addr;
    logic [FU_NUM-1:0][VW-1:0]    fu_val;
    logic                         cdb_ready;
    logic [LANES-1:0]             cdb_valid;
    logic [LANES-1:0][AW-1:0]     cdb_addr;
    logic [LANES-1:0][VW-1:0]     cdb_val;
    logic [LANES-1:0][IW-1:0]     cdb_idx;

    logic [FU_NUM-1:0]            f2_valid;
    logic [FU_NUM-1:0]            f2_ready;
    logic [FU_NUM-1:0][AW-1:0]    f2_addr;
    logic [FU_NUM-1:0][VW-1:0]    f2_val;
    logic                         c2_ready;
    logic [0:0]                   c2_valid;
    logic [0:0][AW-1:0]           c2_addr;
    logic [0:0][VW-1:0]           c2_val;
    logic [0:0][IW-1:0]           c2_idx;

`ifdef CDB_BROADCASTER_STATS_EN
    logic [31:0] stat_bc, stat_st, stat2_bc, stat2_st;
`endif

    cdb_broadcaster #(.FU_NUM(FU_NUM), .CDB_LANES(LANES), .FIFO_DEPTH(DEPTH),
                      .PHYSICAL_REG_NUM_WIDTH(AW), .REG_VAL_WIDTH(VW)) dut (
        .clk               (clk),
        .reset             (reset),
        .fu_valid          (fu_valid),
        .fu_ready          (fu_ready),
        .fu_dst_reg_addr   (fu_addr),
        .fu_result_val     (fu_val),
        .cdb_ready         (cdb_ready),
        .cdb_valid         (cdb_valid),
        .cdb_register_addr (cdb_addr),
        .cdb_register_val  (cdb_val),
        .cdb_fu_idx        (cdb_idx)
`ifdef CDB_BROADCASTER_STATS_EN
        ,
        .stat_broadcast_cnt (stat_bc),
        .stat_fu_stall_cnt  (stat_st)
`endif
    );

    cdb_broadcaster #(.FU_NUM(FU_NUM), .CDB_LANES(1), .FIFO_DEPTH(DEPTH),
                      .PHYSICAL_REG_NUM_WIDTH(AW), .REG_VAL_WIDTH(VW)) dut1 (
        .clk               (clk),
        .reset             (reset),
        .fu_valid          (f2_valid),
        .fu_ready          (f2_ready),
        .fu_dst_reg_addr   (f2_addr),
        .fu_result_val     (f2_val),
        .cdb_ready         (c2_ready),
        .cdb_valid         (c2_valid),
        .cdb_register_addr (c2_addr),
        .cdb_register_val  (c2_val),
        .cdb_fu_idx        (c2_idx)
`ifdef CDB_BROADCASTER_STATS_EN
        ,
        .stat_broadcast_cnt (stat2_bc),
        .stat_fu_stall_cnt  (stat2_st)
`endif
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [VW-1:0] v;
    } ent_t;
    typedef struct packed {
        logic [AW-1:0] a;
        logic [VW-1:0] v;
        logic [IW-1:0] i;
    } lane_t;

    // Model: one queue per FU, the list of results currently on the bus, and the scan start.
    ent_t        mq [FU_NUM][$];
    lane_t       m_lane [$];
    int          m_rr;
    logic [31:0] m_bc;
    logic [31:0] m_st;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int j = 0; j < FU_NUM; j++) mq[j].delete();
        m_lane.delete();
        m_rr = 0;
        m_bc = '0;
        m_st = '0;
    endtask

    task automatic model_step();
        logic [FU_NUM-1:0] rdy;
        logic [IW-1:0]     jj;
        ent_t              e;
        int                last;
        if (!reset) return;
        for (int j = 0; j < FU_NUM; j++) rdy[j] = (mq[j].size() != DEPTH);
        if (|(fu_valid & ~rdy)) m_st = m_st + 32'd1;
        if (m_lane.size() == 0 || cdb_ready) begin
            m_lane.delete();
            last = -1;
            for (int i = 0; i < FU_NUM; i++) begin
                jj = IW'((m_rr + i) % FU_NUM);
                if (m_lane.size() < LANES && mq[jj].size() > 0) begin
                    e = mq[jj].pop_front();
                    m_lane.push_back('{a: e.a, v: e.v, i: jj});
                    last = int'(jj);
                end
            end
            if (last >= 0) m_rr = (last + 1) % FU_NUM;
            m_bc = m_bc + 32'(m_lane.size());
        end
        for (int j = 0; j < FU_NUM; j++)
            if (fu_valid[j] && rdy[j]) mq[j].push_back('{a: fu_addr[j], v: fu_val[j]});
    endtask

    task automatic compare();
        logic [LANES-1:0]         ev;
        logic [LANES-1:0][LW-1:0] ed;
        logic [LANES-1:0][LW-1:0] ad;
        logic [FU_NUM-1:0]        er;
        ev = '0;
        ed = '0;
        for (int k = 0; k < LANES; k++) begin
            ad[k] = {cdb_addr[k], cdb_val[k], cdb_idx[k]};
            if (k < m_lane.size()) begin
                ev[k] = 1'b1;
                ed[k] = m_lane[k];
            end
        end
        for (int j = 0; j < FU_NUM; j++) er[j] = (mq[j].size() != DEPTH);
        check("model_fu_ready", 64'(fu_ready), 64'(er));
        check("model_cdb_valid", 64'(cdb_valid), 64'(ev));
        check("model_lane0", 64'(ad[0]), 64'(ed[0]));
        check("model_lane1", 64'(ad[1]), 64'(ed[1]));
`ifdef CDB_BROADCASTER_STATS_EN
        check("model_stat_bc", 64'(stat_bc), 64'(m_bc));
        check("model_stat_st", 64'(stat_st), 64'(m_st));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    logic [VW-1:0] items [4];
    logic [VW-1:0] log_q [$];
    int            k4;
    int            refusals;
    logic          rdy1;
    int            exp5 [6];
`ifdef CDB_BROADCASTER_STATS_EN
    logic [31:0]   st0;
`endif

    initial begin
        reset     = 1'b0;
        fu_valid  = '0;
        fu_addr   = '0;
        fu_val    = '0;
        cdb_ready = 1'b0;
        f2_valid  = '0;
        f2_addr   = '0;
        f2_val    = '0;
        c2_ready  = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_cdb_valid", 64'(cdb_valid), 64'h0);
        check("rst_lanes", 64'({cdb_addr, cdb_idx}), 64'h0);
        check("rst_val", 64'(cdb_val), 64'h0);
        step();
        reset = 1'b1;
        check("rst_fu_ready", 64'(fu_ready), 64'hF);

        // Single result through FU2
        fu_valid  = 4'b0100;
        fu_addr[2] = 6'd5;
        fu_val[2]  = 32'hDEADBEEF;
        cdb_ready = 1'b1;
        step();
        fu_valid = '0;
        check("single_not_bypassed", 64'(cdb_valid), 64'h0);
        step();
        check("single_valid", 64'(cdb_valid), 64'h1);
        check("single_addr", 64'(cdb_addr[0]), 64'd5);
        check("single_val", 64'(cdb_val[0]), 64'hDEADBEEF);
        check("single_idx", 64'(cdb_idx[0]), 64'd2);
        step();
        check("single_drained", 64'(cdb_valid), 64'h0);

        // Reset while lanes and FIFOs are busy
        cdb_ready = 1'b0;
        fu_valid  = 4'b1111;
        for (int j = 0; j < FU_NUM; j++) begin
            fu_addr[j] = AW'(j + 8);
            fu_val[j]  = 32'h5000 + 32'(j);
        end
        step();
        step();
        fu_valid = '0;
        check("busy_before_reset", 64'(cdb_valid), 64'h3);
        reset = 1'b0;
        model_reset();
        #1;
        check("midrst_cdb_valid", 64'(cdb_valid), 64'h0);
        check("midrst_fu_ready", 64'(fu_ready), 64'hF);
        check("midrst_lanes", 64'({cdb_addr, cdb_idx}), 64'h0);
        step();
        reset     = 1'b1;
        cdb_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("no_stale_after_reset", 64'(cdb_valid), 64'h0);
        end

        // All four FUs push together; rr_ptr starts at 0
        fu_valid = 4'b1111;
        for (int j = 0; j < FU_NUM; j++) begin
            fu_addr[j] = AW'(j + 1);
            fu_val[j]  = 32'h100 + 32'(j);
        end
        step();
        fu_valid = '0;
        step();
        check("all4_first_valid", 64'(cdb_valid), 64'h3);
        check("all4_first_idx", 64'({cdb_idx[1], cdb_idx[0]}), 64'h4);
        check("all4_first_addr", 64'({cdb_addr[1], cdb_addr[0]}), 64'h81);
        step();
        check("all4_second_valid", 64'(cdb_valid), 64'h3);
        check("all4_second_idx", 64'({cdb_idx[1], cdb_idx[0]}), 64'hE);
        check("all4_second_val", 64'(cdb_val[1]), 64'h103);
`ifdef CDB_BROADCASTER_STATS_EN
        check("stat_broadcast_4", 64'(stat_bc), 64'd4);
`endif
        fu_valid = 4'b1001;
        step();
        fu_valid = '0;
        step();
        check("rr_back_to_0", 64'({cdb_idx[1], cdb_idx[0]}), 64'hC);
        step();

        // Backpressure on FU1 with cdb_ready held low
        items[0] = 32'hAAAA0001;
        items[1] = 32'hBBBB0002;
        items[2] = 32'hCCCC0003;
        items[3] = 32'hDDDD0004;
        k4        = 0;
        refusals  = 0;
        cdb_ready = 1'b0;
`ifdef CDB_BROADCASTER_STATS_EN
        st0 = stat_st;
`endif
        for (int c = 0; c < 12; c++) begin
            if (c == 6) cdb_ready = 1'b1;
            if (k4 < 4) begin
                fu_valid   = 4'b0010;
                fu_addr[1] = AW'(20 + k4);
                fu_val[1]  = items[k4];
            end else begin
                fu_valid = '0;
            end
            rdy1 = fu_ready[1];
            if (fu_valid[1] && !rdy1) refusals++;
            if (cdb_ready && cdb_valid[0]) log_q.push_back(cdb_val[0]);
            if (c == 3) begin
                check("bp_fu_ready_low", 64'(fu_ready[1]), 64'h0);
                check("bp_lane0_held", 64'({cdb_valid, cdb_val[0]}), {30'h0, 2'b01, 32'hAAAA0001});
            end
            step();
            if (fu_valid[1] && rdy1) k4++;
        end
        check("bp_refusals", 64'(refusals), 64'd4);
        check("bp_broadcast_count", 64'(log_q.size()), 64'd4);
        for (int n = 0; n < 4; n++)
            if (n < log_q.size()) check("bp_order", 64'(log_q[n]), 64'(items[n]));
`ifdef CDB_BROADCASTER_STATS_EN
        check("stat_stall_delta", 64'(stat_st - st0), 64'(refusals));
`endif

        // Fairness on the single-lane instance
        check("fair_fu_ready", 64'(f2_ready), 64'hF);
        exp5     = '{0, 3, 0, 3, 0, 3};
        f2_valid = 4'b1001;
        f2_addr[0] = 6'd10;
        f2_addr[3] = 6'd13;
        f2_val[0]  = 32'hA0;
        f2_val[3]  = 32'hA3;
        c2_ready = 1'b1;
        step();
        check("fair_first_empty", 64'(c2_valid), 64'h0);
        for (int n = 0; n < 6; n++) begin
            step();
            check("fair_valid", 64'(c2_valid), 64'h1);
            check("fair_idx", 64'(c2_idx[0]), 64'(exp5[n]));
            check("fair_addr", 64'(c2_addr[0]), (exp5[n] == 0) ? 64'd10 : 64'd13);
            check("fair_val", 64'(c2_val[0]), (exp5[n] == 0) ? 64'hA0 : 64'hA3);
        end
        f2_valid = '0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
